// File: rtl/reg_port_master.sv
// Request FIFO + sequencer driving a single-cycle-latency storage register port.
// Optional readback check of every write: define READBACK_VERIFY_EN.
module reg_port_master #(
  parameter int W     = 16,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [W-1:0]     req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_rdata,
  output logic             rsp_err,
  output logic             reg_rw,
  output logic [W-1:0]     reg_wdata,
  input  logic [W-1:0]     reg_rdata,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic         write;
    logic [W-1:0] wdata;
  } req_t;

`ifdef READBACK_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_CAPT, RESP, RB_ISSUE, RB_CAPT} state_t;
`else
  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_CAPT, RESP} state_t;
`endif

  state_t state, state_next;

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, empty, full;
  req_t          head;

  assign empty     = (count == '0);
  assign full      = (count == CNT_FULL);
  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty;

  // NOTE: storage array has no reset; only pointers and count do, which is
  // enough to make stale entries unreachable and keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{write: req_write, wdata: req_wdata};
  end

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = head.write ? WR : RD_ISSUE;
        end
      end
`ifdef READBACK_VERIFY_EN
      WR:       state_next = RB_ISSUE;
      RB_ISSUE: state_next = RB_CAPT;
      RB_CAPT:  state_next = RESP;
`else
      WR:       state_next = RESP;
`endif
      RD_ISSUE: state_next = RD_CAPT;
      RD_CAPT:  state_next = RESP;
      RESP:     if (rsp_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state
  // they belong to; reg_wdata doubles as the in-flight write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      reg_rw    <= 1'b0;
      reg_wdata <= '0;
      txn_count <= '0;
    end else begin
      reg_rw    <= (state_next == WR);
      rsp_valid <= (state_next == RESP);
      if (pop && head.write)       reg_wdata <= head.wdata;
      if (state == WR)             rsp_rdata <= reg_wdata;
      if (state == RD_CAPT)        rsp_rdata <= reg_rdata;
      if (rsp_valid && rsp_ready)  txn_count <= txn_count + CNT_W'(1);
    end
  end

`ifdef READBACK_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else begin
      case (state)
        WR, RD_CAPT: rsp_err <= 1'b0;
        RB_CAPT:     rsp_err <= (reg_rdata != reg_wdata);
        default:     ;
      endcase
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_port_master.sv
// Bench for reg_port_master: models the storage register, predicts responses
// from request order, and checks latency, backpressure, reset and counter wrap.
module tb_reg_port_master;

  localparam int W     = 16;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int RD_LAT = 3;
`ifdef READBACK_VERIFY_EN
  localparam int WR_LAT = 4;
`else
  localparam int WR_LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready, req_write;
  logic [W-1:0]     req_wdata;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [W-1:0]     rsp_rdata;
  logic             reg_rw;
  logic [W-1:0]     reg_wdata, reg_rdata;
  logic             busy;
  logic [CNT_W-1:0] txn_count;

  reg_port_master #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .reg_rw(reg_rw), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  // Storage register: no reset, one-cycle registered read.
  logic [W-1:0] reg_mem = '0;
  logic [W-1:0] reg_q   = '0;
  logic         force_zero = 1'b0;
  always @(posedge clk) begin
    if (reg_rw) reg_mem <= reg_wdata;
    else        reg_q   <= reg_mem;
  end
  assign reg_rdata = force_zero ? '0 : reg_q;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rw_cycles = 0;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (reg_rw === 1'b1) rw_cycles++;

  // Reference model: responses come back in request order; a write's response
  // echoes its data, a read returns the most recent write.
  typedef struct {
    logic [W-1:0] rdata;
    logic         err;
  } rsp_t;
  rsp_t         exp_q[$];
  logic [W-1:0] model_mem = '0;
  int           exp_txn = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_txn++;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic issue(input logic w, input logic [W-1:0] d, output int waited);
    rsp_t e;
    waited = 0;
    req_valid = 1'b1;
    req_write = w;
    req_wdata = d;
    while (req_ready !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    if (req_ready === 1'b1) tick();
    req_valid = 1'b0;
    if (w) begin
      model_mem = d;
      e.rdata = d;
      e.err   = force_zero;
    end else begin
      e.rdata = model_mem;
      e.err   = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_err, reg_rw, busy, req_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_flags: got valid/err/rw/busy/ready=%b, expected 00001",
               {rsp_valid, rsp_err, reg_rw, busy, req_ready});
    end
    checks++;
    if (rsp_rdata !== '0 || reg_wdata !== '0 || txn_count !== '0) begin
      errors++;
      $display("FAIL reset_values: got rdata=%h wdata=%h txn=%0d, expected 0/0/0",
               rsp_rdata, reg_wdata, txn_count);
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_first_read();
    int n, wt;
    rsp_t e;
    issue(1'b0, W'($urandom), wt);
    wait_rsp(n);
    checks++;
    if (n !== RD_LAT) begin
      errors++; $display("FAIL first_read_latency: got %0d cycles, expected %0d", n, RD_LAT);
    end
    e = exp_q.pop_front();
    checks++;
    if (rsp_rdata !== 16'h0000 || rsp_rdata !== e.rdata || rsp_err !== 1'b0) begin
      errors++; $display("FAIL first_read_data: got %h err=%b, expected 0000 err=0", rsp_rdata, rsp_err);
    end
    ack();
    checks++;
    if (txn_count !== CNT_W'(exp_txn) || txn_count !== CNT_W'(1)) begin
      errors++; $display("FAIL first_read_count: got %0d, expected 1", txn_count);
    end
  endtask

  task automatic test_write_read();
    int n, wt;
    rsp_t e;
    rw_cycles = 0;
    issue(1'b1, 16'hA5A5, wt);
    wait_rsp(n);
    checks++;
    if (n !== WR_LAT) begin
      errors++; $display("FAIL write_latency: got %0d cycles, expected %0d", n, WR_LAT);
    end
    e = exp_q.pop_front();
    checks++;
    if (rsp_rdata !== e.rdata || rsp_err !== 1'b0) begin
      errors++; $display("FAIL write_rsp: got %h err=%b, expected %h err=0", rsp_rdata, rsp_err, e.rdata);
    end
    ack();
    issue(1'b0, W'($urandom), wt);
    wait_rsp(n);
    e = exp_q.pop_front();
    checks++;
    if (n !== RD_LAT || rsp_rdata !== e.rdata || rsp_rdata !== 16'hA5A5) begin
      errors++; $display("FAIL read_back: got %h after %0d cycles, expected A5A5 after %0d", rsp_rdata, n, RD_LAT);
    end
    ack();
    checks++;
    if (rw_cycles !== 1) begin
      errors++; $display("FAIL rw_pulse: got reg_rw high %0d cycles, expected 1", rw_cycles);
    end
  endtask

  task automatic test_fifo_full();
    int n, wt, bad;
    logic [W-1:0] held;
    rsp_t e;
    rsp_ready = 1'b0;
    issue(1'b1, W'($urandom), wt);
    wait_rsp(n);
    held = rsp_rdata;
    issue(1'b0, W'($urandom), wt);
    checks++;
    if (wt !== 0) begin
      errors++; $display("FAIL fifo_accept_1: got %0d wait cycles, expected 0", wt);
    end
    issue(1'b1, W'($urandom), wt);
    checks++;
    if (wt !== 0) begin
      errors++; $display("FAIL fifo_accept_2: got %0d wait cycles, expected 0", wt);
    end
    req_valid = 1'b1; req_write = 1'b1; req_wdata = W'($urandom);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (req_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== held) bad++;
      tick();
    end
    req_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL fifo_full_hold: got %0d cycles not full/stable, expected 0", bad);
    end
    for (int i = 0; i < 3; i++) begin
      wait_rsp(n);
      e = exp_q.pop_front();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        errors++; $display("FAIL fifo_drain_%0d: got %h err=%b, expected %h err=%b", i, rsp_rdata, rsp_err, e.rdata, e.err);
      end
      ack();
    end
  endtask

  task automatic test_back_to_back();
    int wt, got, n;
    int stamp[3];
    logic [W-1:0] last;
    rsp_t e;
    got = 0; n = 0; last = '0;
    rsp_ready = 1'b1;
    fork
      begin
        issue(1'b1, 16'h1234, wt);
        issue(1'b1, 16'hBEEF, wt);
        issue(1'b0, W'($urandom), wt);
      end
      begin
        while (got < 3 && n < 200) begin
          tick();
          n++;
          if (rsp_valid === 1'b1) begin
            e = exp_q.pop_front();
            checks++;
            if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
              errors++; $display("FAIL b2b_rsp_%0d: got %h err=%b, expected %h err=%b", got, rsp_rdata, rsp_err, e.rdata, e.err);
            end
            last = rsp_rdata;
            stamp[got] = cyc;
            got++;
            exp_txn++;
          end
        end
      end
    join
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (got !== 3 || last !== 16'hBEEF) begin
      errors++; $display("FAIL b2b_read: got %0d responses, last %h, expected 3, BEEF", got, last);
    end
    checks++;
    if (stamp[1] - stamp[0] !== WR_LAT + 1 || stamp[2] - stamp[1] !== RD_LAT + 1) begin
      errors++; $display("FAIL b2b_spacing: got %0d/%0d cycles, expected %0d/%0d",
                         stamp[1] - stamp[0], stamp[2] - stamp[1], WR_LAT + 1, RD_LAT + 1);
    end
  endtask

  task automatic test_reset_mid();
    int n, wt;
    logic [W-1:0] v, saved;
    rsp_t e;
    v = W'($urandom);
    issue(1'b1, v, wt);
    wait_rsp(n);
    e = exp_q.pop_front();
    ack();
    saved = model_mem;
    issue(1'b0, W'($urandom), wt);
    issue(1'b1, ~v, wt);
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || txn_count !== '0 || reg_rw !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got valid=%b busy=%b txn=%0d rw=%b, expected 0/0/0/0",
                         rsp_valid, busy, txn_count, reg_rw);
    end
    exp_q.delete();
    model_mem = saved;
    exp_txn = 0;
    #1 rst_n = 1'b1;
    tick();
    issue(1'b0, W'($urandom), wt);
    wait_rsp(n);
    e = exp_q.pop_front();
    checks++;
    if (n !== RD_LAT || rsp_rdata !== e.rdata || rsp_rdata !== v) begin
      errors++; $display("FAIL reset_readback: got %h after %0d cycles, expected %h after %0d", rsp_rdata, n, v, RD_LAT);
    end
    ack();
  endtask

`ifdef READBACK_VERIFY_EN
  task automatic test_readback_verify();
    int n, wt;
    rsp_t e;
    force_zero = 1'b1;
    issue(1'b1, 16'h00FF, wt);
    wait_rsp(n);
    e = exp_q.pop_front();
    checks++;
    if (n !== 4 || rsp_rdata !== 16'h00FF || rsp_err !== 1'b1 || rsp_err !== e.err) begin
      errors++; $display("FAIL verify_err: got %h err=%b after %0d, expected 00FF err=1 after 4", rsp_rdata, rsp_err, n);
    end
    ack();
    force_zero = 1'b0;
    issue(1'b1, 16'h0F0F, wt);
    wait_rsp(n);
    e = exp_q.pop_front();
    checks++;
    if (rsp_rdata !== e.rdata || rsp_err !== 1'b0) begin
      errors++; $display("FAIL verify_ok: got %h err=%b, expected %h err=0", rsp_rdata, rsp_err, e.rdata);
    end
    ack();
  endtask
`endif

  task automatic test_random();
    int wt, got, n;
    rsp_t e;
    got = 0; n = 0;
    rsp_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          issue(1'($urandom), W'($urandom), wt);
        end
      end
      begin
        while (got < 40 && n < 3000) begin
          tick();
          n++;
          rsp_ready = 1'b0;
          if (rsp_valid === 1'b1 && $urandom_range(0, 1) == 1) begin
            rsp_ready = 1'b1;
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL rand_extra: got response %h, expected none", rsp_rdata);
            end else begin
              e = exp_q.pop_front();
              if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                errors++; $display("FAIL rand_rsp_%0d: got %h err=%b, expected %h err=%b", got, rsp_rdata, rsp_err, e.rdata, e.err);
              end
            end
            got++;
            exp_txn++;
          end
        end
      end
    join
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (got !== 40) begin
      errors++; $display("FAIL rand_count: got %0d responses, expected 40", got);
    end
    checks++;
    if (txn_count !== CNT_W'(exp_txn) || busy !== 1'b0) begin
      errors++; $display("FAIL rand_txn_wrap: got txn=%0d busy=%b, expected %0d busy=0", txn_count, busy, CNT_W'(exp_txn));
    end
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_write_read();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid();
`ifdef READBACK_VERIFY_EN
    test_readback_verify();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
